eth_arp_tx: RTL and testbench

- Transmit-side partner of the ARP frame receiver on the same MII-style 4-bit interface.
- On a start request, serialises one complete Ethernet ARP frame as nibbles on tx_data/tx_en:
  - preamble and SFD
  - Ethernet header
  - 28-byte ARP body
  - 18 bytes of zero padding
  - 4-byte FCS
- Sits between the ARP reply/request control logic and the PHY transmit pins, and runs on the same clock as the receiver.

---
 rtl/eth_arp_pkg.sv | 30 +++
 rtl/eth_crc32_nibble.sv | 17 +
 rtl/eth_arp_tx.sv | 160 ++++++++++++++++
 tb/tb_eth_arp_tx.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/eth_arp_pkg.sv
// Shared constants and transmit state encoding for the Ethernet ARP datapath.
package eth_arp_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [15:0] ETYPE_ARP     = 16'h0806;
  localparam logic [15:0] HTYPE_ETH     = 16'h0001;
  localparam logic [15:0] PTYPE_IPV4    = 16'h0800;
  localparam logic [7:0]  HLEN          = 8'd6;
  localparam logic [7:0]  PLEN          = 8'd4;
  localparam logic [15:0] ARP_OP_REQ    = 16'd1;
  localparam logic [15:0] ARP_OP_REP    = 16'd2;

  // dst_mac, src_mac, ethertype and the 28-byte ARP body, shifted out MSB-first
  localparam int HDR_W = 336;

  typedef enum logic [3:0] {
    TX_IDLE,
    TX_PRE,
    TX_SFD,
    TX_DMAC,
    TX_SMAC,
    TX_ETYPE,
    TX_ARP,
    TX_PAD,
    TX_FCS,
    TX_IFG
  } tx_state_e;

endpackage

// File: rtl/eth_crc32_nibble.sv
// Combinational one-nibble step of the reflected IEEE 802.3 CRC-32 (LSB of the nibble first).
module eth_crc32_nibble (
  input  logic [31:0] crc_in,
  input  logic [3:0]  nibble,
  output logic [31:0] crc_out
);

  localparam logic [31:0] POLY_REFL = 32'hEDB88320;

  always_comb begin
    crc_out = crc_in ^ {28'h0, nibble};
    for (int i = 0; i < 4; i++) begin
      crc_out = crc_out[0] ? ((crc_out >> 1) ^ POLY_REFL) : (crc_out >> 1);
    end
  end

endmodule

// File: rtl/eth_arp_tx.sv
// Serialises one Ethernet ARP frame as MII nibbles (low nibble first) per start request.
// Define ARP_TX_CRC_EN to generate the FCS internally instead of sending fcs_in.
module eth_arp_tx
  import eth_arp_pkg::*;
#(
  parameter int PAD_BYTES   = 18,
  parameter int IFG_NIBBLES = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [47:0] dst_mac,
  input  logic [47:0] src_mac,
  input  logic [15:0] opcode,
  input  logic [47:0] sha,
  input  logic [31:0] spa,
  input  logic [47:0] tha,
  input  logic [31:0] tpa,
  input  logic [31:0] fcs_in,
  output logic [3:0]  tx_data,
  output logic        tx_en,
  output logic        busy,
  output logic        done
);

  tx_state_e        state, state_nxt;
  logic [5:0]       byte_cnt;
  logic             phase;
  logic [5:0]       ifg_cnt;
  logic [5:0]       field_len;
  logic             byte_last;
  logic             accept;
  logic             in_frame;
  logic             ifg_last;
  logic [7:0]       cur_byte;
  logic [HDR_W-1:0] hdr_sr;
  logic [31:0]      fcs_sr;

  assign accept    = (state == TX_IDLE) && start;
  assign in_frame  = (state != TX_IDLE) && (state != TX_IFG);
  assign ifg_last  = (state == TX_IFG) && (ifg_cnt == 6'(IFG_NIBBLES - 1));
  assign byte_last = phase && (byte_cnt == field_len - 6'd1);

  always_comb begin
    field_len = 6'd1;
    case (state)
      TX_PRE:            field_len = 6'd7;
      TX_DMAC, TX_SMAC:  field_len = 6'd6;
      TX_ETYPE:          field_len = 6'd2;
      TX_ARP:            field_len = 6'd28;
      TX_PAD:            field_len = 6'(PAD_BYTES);
      TX_FCS:            field_len = 6'd4;
      default:           field_len = 6'd1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= TX_IDLE;
      byte_cnt <= 6'd0;
      phase    <= 1'b0;
      ifg_cnt  <= 6'd0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        byte_cnt <= 6'd0;
        phase    <= 1'b0;
      end else if (in_frame) begin
        phase <= ~phase;
        if (phase) byte_cnt <= byte_cnt + 6'd1;
      end
      ifg_cnt <= (state == TX_IFG && state_nxt == TX_IFG) ? ifg_cnt + 6'd1 : 6'd0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      TX_IDLE:  if (start)     state_nxt = TX_PRE;
      TX_PRE:   if (byte_last) state_nxt = TX_SFD;
      TX_SFD:   if (byte_last) state_nxt = TX_DMAC;
      TX_DMAC:  if (byte_last) state_nxt = TX_SMAC;
      TX_SMAC:  if (byte_last) state_nxt = TX_ETYPE;
      TX_ETYPE: if (byte_last) state_nxt = TX_ARP;
      TX_ARP:   if (byte_last) state_nxt = (PAD_BYTES == 0) ? TX_FCS : TX_PAD;
      TX_PAD:   if (byte_last) state_nxt = TX_FCS;
      TX_FCS:   if (byte_last) state_nxt = TX_IFG;
      TX_IFG:   if (ifg_last)  state_nxt = TX_IDLE;
      default:                 state_nxt = TX_IDLE;
    endcase
  end

  always_comb begin
    cur_byte = 8'h00;
    case (state)
      TX_PRE:                             cur_byte = PREAMBLE_BYTE;
      TX_SFD:                             cur_byte = SFD_BYTE;
      TX_DMAC, TX_SMAC, TX_ETYPE, TX_ARP: cur_byte = hdr_sr[HDR_W-1 -: 8];
      TX_FCS:                             cur_byte = fcs_sr[31:24];
      default:                            cur_byte = 8'h00;
    endcase
    tx_en   = in_frame;
    tx_data = in_frame ? (phase ? cur_byte[7:4] : cur_byte[3:0]) : 4'h0;
    busy    = (state != TX_IDLE);
    done    = ifg_last;
  end

  // Header fields are captured once at accept and then shifted out a byte at a time.
  always_ff @(posedge clk) begin
    if (accept) begin
      hdr_sr <= {dst_mac, src_mac, ETYPE_ARP, HTYPE_ETH, PTYPE_IPV4, HLEN, PLEN,
                 opcode, sha, spa, tha, tpa};
    end else if (phase && (state inside {TX_DMAC, TX_SMAC, TX_ETYPE, TX_ARP})) begin
      hdr_sr <= hdr_sr << 8;
    end
  end

`ifdef ARP_TX_CRC_EN
  logic [31:0] crc_q, crc_nxt;
  logic        unused_fcs;

  assign unused_fcs = ^fcs_in;

  eth_crc32_nibble u_crc (
    .crc_in  (crc_q),
    .nibble  (tx_data),
    .crc_out (crc_nxt)
  );

  // Byte-swap so the existing MSB-first FCS shifter emits crc[7:0] first.
  function automatic logic [31:0] wire_order(input logic [31:0] crc);
    return {crc[7:0], crc[15:8], crc[23:16], crc[31:24]};
  endfunction

  always_ff @(posedge clk) begin
    if (accept) begin
      crc_q <= 32'hFFFF_FFFF;
    end else if (state inside {TX_DMAC, TX_SMAC, TX_ETYPE, TX_ARP, TX_PAD}) begin
      crc_q <= crc_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (state == TX_FCS && phase) begin
      fcs_sr <= fcs_sr << 8;
    end else if (state_nxt == TX_FCS && state != TX_FCS) begin
      fcs_sr <= wire_order(~crc_nxt);
    end
  end
`else
  always_ff @(posedge clk) begin
    if (accept) begin
      fcs_sr <= fcs_in;
    end else if (state == TX_FCS && phase) begin
      fcs_sr <= fcs_sr << 8;
    end
  end
`endif

endmodule

// File: tb/tb_eth_arp_tx.sv
// Scoreboard bench for eth_arp_tx: expected nibbles are queued at start and popped as tx_en runs.
// Honours ARP_TX_CRC_EN for the expected FCS and the CRC residue check.
module tb_eth_arp_tx;

  localparam int PAD = 18;
  localparam int IFG = 24;
  localparam int FRAME_NIB = 2 * (8 + 14 + 28 + PAD + 4);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [47:0] dst_mac = '0, src_mac = '0, sha = '0, tha = '0;
  logic [15:0] opcode = '0;
  logic [31:0] spa = '0, tpa = '0, fcs_in = '0;
  logic [3:0]  tx_data;
  logic        tx_en, busy, done;

  int checks = 0;
  int failures = 0;
  logic [3:0] exp_q[$];
  logic [3:0] cap_q[$];
  logic [7:0] exp_bytes[$];
  int en_cnt, done_cnt, idle_run, done_gap;

  eth_arp_tx #(.PAD_BYTES(PAD), .IFG_NIBBLES(IFG)) dut (
    .clk(clk), .rst(rst), .start(start),
    .dst_mac(dst_mac), .src_mac(src_mac), .opcode(opcode),
    .sha(sha), .spa(spa), .tha(tha), .tpa(tpa), .fcs_in(fcs_in),
    .tx_data(tx_data), .tx_en(tx_en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Monitor: every transmitted nibble is checked against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_en) begin
        cap_q.push_back(tx_data);
        en_cnt++;
        idle_run = 0;
        chk("queue_nonempty", (exp_q.size() != 0), 1'b1);
        if (exp_q.size() != 0) chk("nibble", tx_data, exp_q.pop_front());
      end else begin
        chk("idle_data_zero", tx_data, 4'h0);
        if (busy) idle_run++;
      end
      if (done) begin
        done_cnt++;
        done_gap = idle_run;
      end
    end
  end

  task automatic push_field(input logic [47:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) exp_bytes.push_back(v[8*i +: 8]);
  endtask

  task automatic build_expected();
    logic [31:0] f, c;
    exp_bytes.delete();
    for (int i = 0; i < 7; i++) exp_bytes.push_back(8'h55);
    exp_bytes.push_back(8'hD5);
    push_field(dst_mac, 6);
    push_field(src_mac, 6);
    push_field(48'h0806, 2);
    push_field(48'h0001, 2);
    push_field(48'h0800, 2);
    push_field(48'h06, 1);
    push_field(48'h04, 1);
    push_field({32'h0, opcode}, 2);
    push_field(sha, 6);
    push_field({16'h0, spa}, 4);
    push_field(tha, 6);
    push_field({16'h0, tpa}, 4);
    for (int i = 0; i < PAD; i++) exp_bytes.push_back(8'h00);
`ifdef ARP_TX_CRC_EN
    c = 32'hFFFF_FFFF;
    for (int i = 8; i < exp_bytes.size(); i++) c = crc_byte(c, exp_bytes[i]);
    c = ~c;
    f = {c[7:0], c[15:8], c[23:16], c[31:24]};
`else
    c = 32'h0;
    f = fcs_in;
`endif
    push_field({16'h0, f}, 4);
    foreach (exp_bytes[i]) begin
      exp_q.push_back(exp_bytes[i][3:0]);
      exp_q.push_back(exp_bytes[i][7:4]);
    end
  endtask

  task automatic run_frame(input string name, input int restart_at, input int rst_at);
    logic [47:0] sv_dst;
    logic [31:0] sv_fcs, res;
    bit seen_done, aborted;
    sv_dst = dst_mac;
    sv_fcs = fcs_in;
    exp_q.delete();
    build_expected();
    en_cnt = 0; done_cnt = 0; idle_run = 0; done_gap = -1;
    cap_q.delete();
    seen_done = 0; aborted = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk({name, "_busy_n1"}, busy, 1'b1);
    chk({name, "_tx_en_n1"}, tx_en, 1'b1);
    for (int k = 0; k < 400 && !seen_done; k++) begin
      if (k == restart_at) begin
        dst_mac = ~dst_mac;
        fcs_in  = ~fcs_in;
        start   = 1'b1;
      end
      if (k == rst_at) begin
        #2 rst = 1'b1;
        #1;
        chk({name, "_rst_tx_en"}, tx_en, 1'b0);
        chk({name, "_rst_busy"}, busy, 1'b0);
        aborted = 1;
        break;
      end
      @(posedge clk); #1 start = 1'b0;
      if (done) seen_done = 1;
    end
    dst_mac = sv_dst;
    fcs_in  = sv_fcs;
    if (aborted) begin
      repeat (3) @(posedge clk);
      exp_q.delete();
      #1 rst = 1'b0;
      @(posedge clk); #1;
      chk({name, "_post_rst_busy"}, busy, 1'b0);
      chk({name, "_post_rst_tx_en"}, tx_en, 1'b0);
      return;
    end
    chk({name, "_done_seen"}, seen_done, 1'b1);
    // A start coincident with done must not be accepted.
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk({name, "_busy_after_done"}, busy, 1'b0);
    repeat (2) @(posedge clk);
    #1 chk({name, "_start_at_done_ignored"}, busy, 1'b0);
    chk({name, "_tx_en_cycles"}, en_cnt, FRAME_NIB);
    chk({name, "_done_pulses"}, done_cnt, 1);
    chk({name, "_ifg_len"}, done_gap, IFG);
    chk({name, "_queue_drained"}, exp_q.size(), 0);
`ifdef ARP_TX_CRC_EN
    res = 32'hFFFF_FFFF;
    for (int i = 8; i < FRAME_NIB / 2; i++) res = crc_byte(res, {cap_q[2*i+1], cap_q[2*i]});
    res = {<<{res}};
    chk({name, "_crc_residue"}, res, 32'hC704DD7B);
`else
    res = 32'h0;
`endif
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx_en", tx_en, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_tx_data", tx_data, 4'h0);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      chk("idle_tx_en", tx_en, 1'b0);
      chk("idle_busy", busy, 1'b0);
      chk("idle_done", done, 1'b0);
    end

    dst_mac = 48'hFFFF_FFFF_FFFF;
    src_mac = 48'h000A_3501_0203;
    sha     = 48'h000A_3501_0203;
    opcode  = 16'd1;
    spa     = 32'hC0A8_0001;
    tha     = 48'h0;
    tpa     = 32'hC0A8_0002;
    fcs_in  = 32'hDEAD_BEEF;
    run_frame("req", -1, -1);
    run_frame("restart_ignored", 40, -1);
    fcs_in = 32'h1234_5678;
    run_frame("second_frame", -1, -1);
    run_frame("abort", -1, 60);

    dst_mac = 48'h000A_3501_0203;
    src_mac = 48'h0200_5E10_2030;
    sha     = 48'h0200_5E10_2030;
    opcode  = 16'd2;
    spa     = 32'hC0A8_0002;
    tha     = 48'h000A_3501_0203;
    tpa     = 32'hC0A8_0001;
    fcs_in  = 32'hA5C3_0F96;
    run_frame("reply_after_abort", -1, -1);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
